mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency) between two requesters: the instruction-fetch port and the Execute-stage data port.
- Data-port inputs take Execute's registered memory outputs directly: address, read lane mask, sign-extend flag, write lane mask, write data.
- Returns fetch words and load data to the writeback path, already aligned and sign- or zero-extended.
- Data has priority; a starvation counter guarantees fetch progress, and a 1-entry skid buffer holds a data request that loses arbitration.

Parameters:
- ADDR_W, 12: RAM word-address width (RAM depth is 2^ADDR_W words).
- STARVE_MAX, 4: consecutive denied fetch cycles before fetch is forced to win one conflict; legal range 1..15.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst_n  in  1  Reset; asynchronous, active-low.
- d_addr  in  32  Data byte address.
- d_rden  in  4  Load lane mask.
- d_rden_sext  in  1  1 = sign-extend the loaded byte/half.
- d_wren  in  4  Store lane mask.
- d_wrdata  in  32  Store data, already lane-replicated.
- d_stall  out  1  Skid buffer occupied; upstream must not issue a new request.
- d_rvld  out  1  Load response valid (1-cycle pulse).
- d_rdata  out  32  Aligned and extended load data.
- f_req  in  1  Fetch request; held until granted.
- f_addr  in  32  Fetch byte address, word-aligned.
- f_gnt  out  1  Fetch granted this cycle (combinational).
- f_rvld  out  1  Fetch response valid (1-cycle pulse).
- f_rdata  out  32  Fetched instruction word.
- ram_en  out  1  RAM access enable.
- ram_addr  out  ADDR_W  RAM word address (byte address bits [ADDR_W+1:2]).
- ram_we  out  4  RAM byte write enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid one cycle after a read.

Behaviour:
- Reset: all registered outputs 0, skid buffer empty, starve_cnt 0, any in-flight response discarded.
- Live data request: |d_rden or |d_wren. Data pending: buffer full or live request. The buffered entry is always served before a live one.
- A live request while d_stall=1 is a protocol violation. It is dropped and the bench asserts on it.
- Arbitration, evaluated every cycle:
  - Only one requester pending: it wins.
  - Both pending: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- Losing live data request: captured into the skid buffer. d_stall rises the next cycle and falls the cycle after the buffer drains.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle f_req=1 and f_gnt=0.
  - Clears on f_gnt or when f_req=0.
- RAM drive on a grant: ram_en=1, ram_addr from the winner's address.
  - Data write: ram_we=d_wren, ram_wdata=d_wrdata.
  - Reads: ram_we=0.
- rden and wren both nonzero: the write is performed and no load response is produced.
- Idle cycle: ram_en=0, ram_we=0.
- Read response latency: exactly 1 cycle after the grant. A registered tag (port, lane mask, sext) selects d_rvld or f_rvld.
- Writes produce no response.
- Back-to-back grants every cycle are supported.
- Load alignment by lane mask:
  - 1111: pass the word through.
  - 0011 / 1100: take bits [15:0] / [31:16].
  - 0001 / 0010 / 0100 / 1000: take the corresponding byte.
  - Extension: sign-extend from bit 7 or bit 15 if sext=1, else zero-extend.
  - Any other mask is treated as 1111.
- f_rdata = ram_rdata unmodified. d_rdata and f_rdata hold their value between pulses.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds two outputs, each 32-bit, wrapping, reset to 0:
  - perf_conflict_cnt: cycles with both requesters pending.
  - perf_starve_cnt: cycles in which a starvation override granted fetch.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines: lane-mask constants (LANE_W=1111, LANE_H0=0011, LANE_H1=1100, LANE_B0..LANE_B3) and port-tag encodings (TAG_D, TAG_F).
- One sub-module: mem_load_align, combinational. Inputs: 32-bit word, 4-bit mask, sext. Output: 32-bit aligned result.
- The arbiter FSM, skid buffer and response tag stay in the top module.

Test Plan:
- Load byte: RAM[0x10]=0x80FF7F01; data load addr 0x12, rden 0100, sext=1 -> d_rvld one cycle after the grant, d_rdata=0xFFFFFFFF. Repeat with sext=0 -> 0x000000FF.
- Load half: addr 0x12, rden 1100, sext=1 -> 0xFFFF80FF. Store SH with wren 0011, wrdata 0xBEEFBEEF to 0x20 -> only lanes 0-1 written; a following LW returns 0x????BEEF with the upper half unchanged.
- Conflict: f_req=1 at 0x0 together with a live data load -> data granted, f_gnt=0. Fetch is granted the next cycle with f_rvld one cycle later. No stall occurs because the data request won.
- Starvation: with STARVE_MAX=4, hold f_req and issue a data request every cycle the stall allows -> f_gnt within 5 cycles. The losing data request is buffered, d_stall=1 for exactly 1 cycle, and the buffered request is served next.
- Reset mid-read: assert rst_n=0 in the cycle after a load grant -> no d_rvld, all outputs 0. After release, the first fetch behaves normally.
- PERF (macro defined): 10 conflict cycles with STARVE_MAX=4 -> perf_conflict_cnt=10, perf_starve_cnt=2.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Purpose: shared constants and types for the memory-port arbiter slice.
//   - Lane-mask encodings used by the load aligner and the arbiter.
//   - Response tag encoding (which requester a pending read belongs to).
//   - Packed data-request record held by the skid buffer.
// Optional feature macro used elsewhere in this slice: MEM_ARB_PERF_EN.
package mem_port_arbiter_pkg;

  localparam logic [3:0] LANE_W  = 4'b1111;
  localparam logic [3:0] LANE_H0 = 4'b0011;
  localparam logic [3:0] LANE_H1 = 4'b1100;
  localparam logic [3:0] LANE_B0 = 4'b0001;
  localparam logic [3:0] LANE_B1 = 4'b0010;
  localparam logic [3:0] LANE_B2 = 4'b0100;
  localparam logic [3:0] LANE_B3 = 4'b1000;

  typedef enum logic {
    TAG_D = 1'b0,
    TAG_F = 1'b1
  } port_tag_e;

  // Everything about a data request except its address, whose width
  // depends on the RAM depth parameter of the top level.
  typedef struct packed {
    logic [3:0]  rden;
    logic        sext;
    logic [3:0]  wren;
    logic [31:0] wdata;
  } data_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Purpose: bundles the data port, fetch port and RAM port of the arbiter.
// Modports:
//   master - the surrounding system: Execute data port, fetch unit and RAM
//            (drives requests and ram_rdata, receives responses and RAM drive)
//   slave  - the arbiter itself
// Parameter: ADDR_W - RAM word-address width.
// Optional feature macro of this slice: MEM_ARB_PERF_EN (not used here).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12
);

  logic [31:0]       d_addr;
  logic [3:0]        d_rden;
  logic              d_rden_sext;
  logic [3:0]        d_wren;
  logic [31:0]       d_wrdata;
  logic              d_stall;
  logic              d_rvld;
  logic [31:0]       d_rdata;

  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvld;
  logic [31:0]       f_rdata;

  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport master (
    output d_addr, d_rden, d_rden_sext, d_wren, d_wrdata,
    input  d_stall, d_rvld, d_rdata,
    output f_req, f_addr,
    input  f_gnt, f_rvld, f_rdata,
    input  ram_en, ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  d_addr, d_rden, d_rden_sext, d_wren, d_wrdata,
    output d_stall, d_rvld, d_rdata,
    input  f_req, f_addr,
    output f_gnt, f_rvld, f_rdata,
    output ram_en, ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

endinterface

// File: rtl/mem_load_align.sv
// mem_load_align
// Purpose: combinational load aligner; picks the byte/half/word selected by
// the lane mask and sign- or zero-extends it to 32 bits.
// Ports:
//   word_i [31:0] raw RAM word
//   mask_i [3:0]  load lane mask (unrecognised masks pass the word through)
//   sext_i        1 = sign-extend byte/half results
//   data_o [31:0] aligned, extended result
// Optional feature macro of this slice: MEM_ARB_PERF_EN (not used here).
module mem_load_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [3:0]  mask_i,
  input  logic        sext_i,
  output logic [31:0] data_o
);

  // The extension bit is the top bit of the selected field, gated by sext.
  always_comb begin
    data_o = word_i;
    case (mask_i)
      LANE_W:  data_o = word_i;
      LANE_H0: data_o = {{16{sext_i & word_i[15]}}, word_i[15:0]};
      LANE_H1: data_o = {{16{sext_i & word_i[31]}}, word_i[31:16]};
      LANE_B0: data_o = {{24{sext_i & word_i[7]}},  word_i[7:0]};
      LANE_B1: data_o = {{24{sext_i & word_i[15]}}, word_i[15:8]};
      LANE_B2: data_o = {{24{sext_i & word_i[23]}}, word_i[23:16]};
      LANE_B3: data_o = {{24{sext_i & word_i[31]}}, word_i[31:24]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Purpose: shares one single-port synchronous RAM (1-cycle read latency)
// between the instruction-fetch port and the Execute data port. Data has
// priority, a starvation counter forces fetch through after STARVE_MAX
// denied cycles, and a 1-entry skid buffer keeps a data request that lost.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus (slave)   data port, fetch port and RAM port (mem_port_arbiter_if)
//   perf_conflict_cnt, perf_starve_cnt (only with MEM_ARB_PERF_EN defined)
// Parameters: ADDR_W (RAM word-address width), STARVE_MAX (1..15).
// Optional feature macro: MEM_ARB_PERF_EN adds the two perf counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_starve_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              skidValid_q;
  logic [ADDR_W-1:0] skidAddr_q;
  data_req_t         skidReq_q;
  logic [3:0]        starveCnt_q, starveCnt_d;
  logic              tagValid_q, tagValid_d;
  port_tag_e         tagPort_q, tagPort_d;
  logic [3:0]        tagMask_q;
  logic              tagSext_q;
  logic [31:0]       dLast_q, fLast_q;

  data_req_t         liveFields, selReq;
  logic [ADDR_W-1:0] selAddr;
  logic              liveReq, liveAcc, dataPend, starveHit;
  logic              fetchWin, dataWin, dRvld, fRvld;
  logic [31:0]       alignedWord;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^{bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0],
                            bus.f_addr[31:ADDR_W+2], bus.f_addr[1:0]};

  // A live request arriving while the skid buffer is full is a protocol
  // violation and is ignored; the buffered entry always goes first.
  assign liveFields = '{rden: bus.d_rden, sext: bus.d_rden_sext,
                        wren: bus.d_wren, wdata: bus.d_wrdata};
  assign liveReq    = (|bus.d_rden) | (|bus.d_wren);
  assign liveAcc    = liveReq & ~skidValid_q;
  assign dataPend   = skidValid_q | liveAcc;
  assign starveHit  = (starveCnt_q == STARVE_LIM);
  assign fetchWin   = bus.f_req & (~dataPend | starveHit);
  assign dataWin    = dataPend & ~fetchWin;
  assign selAddr    = skidValid_q ? skidAddr_q : bus.d_addr[ADDR_W+1:2];
  assign selReq     = skidValid_q ? skidReq_q : liveFields;

  assign bus.f_gnt   = fetchWin;
  assign bus.d_stall = skidValid_q;

  // Drive the RAM from whichever requester won this cycle.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_we    = 4'b0000;
    bus.ram_wdata = '0;
    if (dataWin) begin
      bus.ram_en    = 1'b1;
      bus.ram_addr  = selAddr;
      bus.ram_we    = selReq.wren;
      bus.ram_wdata = selReq.wdata;
    end else if (fetchWin) begin
      bus.ram_en    = 1'b1;
      bus.ram_addr  = bus.f_addr[ADDR_W+1:2];
    end
  end

  // Next-state for the starvation counter and the read-response tag.
  // A data grant with any write lanes set is a write and gets no response.
  always_comb begin
    starveCnt_d = 4'd0;
    if (bus.f_req && !fetchWin) begin
      starveCnt_d = starveHit ? starveCnt_q : starveCnt_q + 4'd1;
    end
    tagValid_d = fetchWin | (dataWin & ~(|selReq.wren));
    tagPort_d  = fetchWin ? TAG_F : TAG_D;
  end

  mem_load_align u_align (
    .word_i (bus.ram_rdata),
    .mask_i (tagMask_q),
    .sext_i (tagSext_q),
    .data_o (alignedWord)
  );

  // Responses appear in the cycle after the grant, when the RAM word is
  // valid; between pulses the outputs show the last delivered value.
  assign dRvld       = tagValid_q & (tagPort_q == TAG_D);
  assign fRvld       = tagValid_q & (tagPort_q == TAG_F);
  assign bus.d_rvld  = dRvld;
  assign bus.f_rvld  = fRvld;
  assign bus.d_rdata = dRvld ? alignedWord : dLast_q;
  assign bus.f_rdata = fRvld ? bus.ram_rdata : fLast_q;

  // All arbiter state: skid buffer, starvation counter, response tag and
  // the held response values. Reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skidValid_q <= 1'b0;
      skidAddr_q  <= '0;
      skidReq_q   <= '0;
      starveCnt_q <= 4'd0;
      tagValid_q  <= 1'b0;
      tagPort_q   <= TAG_D;
      tagMask_q   <= 4'b0000;
      tagSext_q   <= 1'b0;
      dLast_q     <= '0;
      fLast_q     <= '0;
    end else begin
      if (liveAcc && fetchWin) begin
        skidValid_q <= 1'b1;
        skidAddr_q  <= bus.d_addr[ADDR_W+1:2];
        skidReq_q   <= liveFields;
      end else if (skidValid_q && dataWin) begin
        skidValid_q <= 1'b0;
      end
      starveCnt_q <= starveCnt_d;
      tagValid_q  <= tagValid_d;
      tagPort_q   <= tagPort_d;
      tagMask_q   <= selReq.rden;
      tagSext_q   <= selReq.sext;
      if (dRvld) dLast_q <= alignedWord;
      if (fRvld) fLast_q <= bus.ram_rdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Conflict = both requesters pending; override = fetch won a conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_cnt <= '0;
      perf_starve_cnt   <= '0;
    end else begin
      if (bus.f_req && dataPend) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (fetchWin && dataPend)  perf_starve_cnt   <= perf_starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Purpose: directed self-checking bench for mem_port_arbiter with a small
// byte-writable RAM model behind the RAM port.
// Optional feature macro: MEM_ARB_PERF_EN enables the perf counter checks.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  logic [31:0] ramMem [0:(1<<ADDR_W)-1];

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perfConflict, perfStarve;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perfConflict),
    .perf_starve_cnt   (perfStarve)
`endif
  );

  // Single-port synchronous RAM: reads return one cycle later.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we == 4'b0000) begin
        bus.ram_rdata <= ramMem[bus.ram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.ram_we[b]) ramMem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Upstream must never present a new request while the arbiter stalls.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.d_stall && ((|bus.d_rden) || (|bus.d_wren))))
        else $error("[TB] protocol violation: request issued during d_stall");
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic setInputs(input logic [31:0] dAddr, input logic [3:0] rden,
                           input logic sext, input logic [3:0] wren,
                           input logic [31:0] wdata, input logic fReq,
                           input logic [31:0] fAddr);
    bus.d_addr      = dAddr;
    bus.d_rden      = rden;
    bus.d_rden_sext = sext;
    bus.d_wren      = wren;
    bus.d_wrdata    = wdata;
    bus.f_req       = fReq;
    bus.f_addr      = fAddr;
  endtask

  // One cycle: drive at the falling edge, then settle before sampling.
  task automatic applyStimulus(input logic [31:0] dAddr, input logic [3:0] rden,
                               input logic sext, input logic [3:0] wren,
                               input logic [31:0] wdata, input logic fReq,
                               input logic [31:0] fAddr);
    @(negedge clk);
    setInputs(dAddr, rden, sext, wren, wdata, fReq, fAddr);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    setInputs(32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_d_stall", {31'b0, bus.d_stall}, 32'h0);
    checkOutput("rst_d_rvld",  {31'b0, bus.d_rvld},  32'h0);
    checkOutput("rst_d_rdata", bus.d_rdata,          32'h0);
    checkOutput("rst_f_rvld",  {31'b0, bus.f_rvld},  32'h0);
    checkOutput("rst_f_rdata", bus.f_rdata,          32'h0);
    checkOutput("rst_ram_en",  {31'b0, bus.ram_en},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload through the data port with full-word stores.
    applyStimulus(32'h10, 4'h0, 1'b0, 4'hF, 32'h80FF7F01, 1'b0, 32'h0);
    checkOutput("sw_we", {28'b0, bus.ram_we}, 32'hF);
    checkOutput("sw_addr", {20'b0, bus.ram_addr}, 32'h4);
    applyStimulus(32'h20, 4'h0, 1'b0, 4'hF, 32'h11223344, 1'b0, 32'h0);
    checkOutput("sw_no_rvld", {31'b0, bus.d_rvld}, 32'h0);
    applyStimulus(32'h00, 4'h0, 1'b0, 4'hF, 32'h00000013, 1'b0, 32'h0);

    // Byte loads, signed and unsigned.
    applyStimulus(32'h12, 4'b0100, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("lb_ram_en", {31'b0, bus.ram_en}, 32'h1);
    checkOutput("lb_ram_we", {28'b0, bus.ram_we}, 32'h0);
    checkOutput("lb_f_gnt",  {31'b0, bus.f_gnt},  32'h0);
    idleCycle();
    checkOutput("lb_rvld",  {31'b0, bus.d_rvld}, 32'h1);
    checkOutput("lb_rdata", bus.d_rdata, 32'hFFFFFFFF);
    checkOutput("lb_f_rvld", {31'b0, bus.f_rvld}, 32'h0);
    idleCycle();
    checkOutput("lb_pulse", {31'b0, bus.d_rvld}, 32'h0);
    checkOutput("lb_hold",  bus.d_rdata, 32'hFFFFFFFF);
    applyStimulus(32'h12, 4'b0100, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("lbu_rdata", bus.d_rdata, 32'h000000FF);

    // Half loads and an odd mask that falls back to the full word.
    applyStimulus(32'h12, 4'b1100, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("lh_hi_rdata", bus.d_rdata, 32'hFFFF80FF);
    applyStimulus(32'h10, 4'b0011, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("lh_lo_rdata", bus.d_rdata, 32'h00007F01);
    applyStimulus(32'h10, 4'b0010, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("lb1_rdata", bus.d_rdata, 32'h0000007F);
    applyStimulus(32'h10, 4'b0101, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("lodd_rdata", bus.d_rdata, 32'h80FF7F01);

    // Store-half to the low lanes, then read the whole word back.
    applyStimulus(32'h20, 4'h0, 1'b0, 4'b0011, 32'hBEEFBEEF, 1'b0, 32'h0);
    checkOutput("sh_we", {28'b0, bus.ram_we}, 32'h3);
    idleCycle();
    checkOutput("sh_no_rvld", {31'b0, bus.d_rvld}, 32'h0);
    applyStimulus(32'h20, 4'hF, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("lw_after_sh", bus.d_rdata, 32'h1122BEEF);

    // Read and write lanes together: the write happens, no response.
    applyStimulus(32'h24, 4'hF, 1'b0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
    checkOutput("rw_we", {28'b0, bus.ram_we}, 32'hF);
    idleCycle();
    checkOutput("rw_no_rvld", {31'b0, bus.d_rvld}, 32'h0);

    // Conflict: data wins, fetch gets the next cycle, no stall.
    applyStimulus(32'h10, 4'hF, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
    checkOutput("cf_f_gnt",    {31'b0, bus.f_gnt}, 32'h0);
    checkOutput("cf_ram_addr", {20'b0, bus.ram_addr}, 32'h4);
    applyStimulus(32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
    checkOutput("cf_f_gnt2",   {31'b0, bus.f_gnt}, 32'h1);
    checkOutput("cf_ram_addr2", {20'b0, bus.ram_addr}, 32'h0);
    checkOutput("cf_d_rvld",   {31'b0, bus.d_rvld}, 32'h1);
    checkOutput("cf_d_rdata",  bus.d_rdata, 32'h80FF7F01);
    checkOutput("cf_stall",    {31'b0, bus.d_stall}, 32'h0);
    idleCycle();
    checkOutput("cf_f_rvld",   {31'b0, bus.f_rvld}, 32'h1);
    checkOutput("cf_f_rdata",  bus.f_rdata, 32'h00000013);

    // Starvation: fetch wins on the fifth conflicting cycle, the losing
    // data request (to 0x24) sits in the skid buffer for one cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 4) ? 32'h24 : 32'h10, 4'hF, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
      checkOutput($sformatf("st_f_gnt_%0d", i), {31'b0, bus.f_gnt}, (i == 4) ? 32'h1 : 32'h0);
      checkOutput($sformatf("st_stall_%0d", i), {31'b0, bus.d_stall}, 32'h0);
      if (i > 0) checkOutput($sformatf("st_d_rvld_%0d", i), {31'b0, bus.d_rvld}, 32'h1);
    end
    applyStimulus(32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
    checkOutput("st_stall_on", {31'b0, bus.d_stall}, 32'h1);
    checkOutput("st_f_gnt_5",  {31'b0, bus.f_gnt}, 32'h0);
    checkOutput("st_skid_addr", {20'b0, bus.ram_addr}, 32'h9);
    checkOutput("st_f_rvld",   {31'b0, bus.f_rvld}, 32'h1);
    idleCycle();
    checkOutput("st_stall_off", {31'b0, bus.d_stall}, 32'h0);
    checkOutput("st_skid_rvld", {31'b0, bus.d_rvld}, 32'h1);
    checkOutput("st_skid_rdata", bus.d_rdata, 32'hCAFEF00D);

    // Reset in the cycle after a load grant drops the response.
    applyStimulus(32'h10, 4'hF, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    setInputs(32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    #1;
    checkOutput("rr_d_rvld",  {31'b0, bus.d_rvld}, 32'h0);
    checkOutput("rr_d_rdata", bus.d_rdata, 32'h0);
    checkOutput("rr_f_rdata", bus.f_rdata, 32'h0);
    checkOutput("rr_ram_en",  {31'b0, bus.ram_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
    checkOutput("rr_f_gnt", {31'b0, bus.f_gnt}, 32'h1);
    idleCycle();
    checkOutput("rr_f_rvld",  {31'b0, bus.f_rvld}, 32'h1);
    checkOutput("rr_f_rdata", bus.f_rdata, 32'h00000013);

    // Ten conflict cycles from a fresh reset: overrides at cycles 4 and 9.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(32'h10, (i == 5) ? 4'h0 : 4'hF, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
      checkOutput($sformatf("pf_f_gnt_%0d", i), {31'b0, bus.f_gnt},
                  (i == 4 || i == 9) ? 32'h1 : 32'h0);
      checkOutput($sformatf("pf_stall_%0d", i), {31'b0, bus.d_stall},
                  (i == 5) ? 32'h1 : 32'h0);
    end
    idleCycle();
    checkOutput("pf_drain_stall", {31'b0, bus.d_stall}, 32'h1);
    checkOutput("pf_drain_en",    {31'b0, bus.ram_en}, 32'h1);
`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_conflict", perfConflict, 32'd10);
    checkOutput("perf_starve",   perfStarve,   32'd2);
`endif
    idleCycle();
    checkOutput("pf_stall_clear", {31'b0, bus.d_stall}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
